// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the run-time clock divider controller.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2,
    STOP = 2'd3
  } state_e;

  localparam int CNT_W_DEF        = 16;
  localparam int DEFAULT_HALF_DEF = 10;

  function automatic logic [31:0] half_clamp(input logic [31:0] v);
    half_clamp = (v == 32'd0) ? 32'd1 : v;
  endfunction

endpackage

// File: rtl/clk_div_core.sv
// Half-period counter, terminal compare, divided-clock toggle and rising-edge tick.
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEF,
  parameter int DEFAULT_HALF = DEFAULT_HALF_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             load_half,
  input  logic [CNT_W-1:0] half_in,
  output logic             clk_o,
  output logic             tick_o,
  output logic             fall_o,
  output logic [CNT_W-1:0] half_cur
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             term;

  // half_q is never 0, so half_q-1 cannot underflow
  assign term   = (cnt_q == (half_q - CNT_W'(1)));
  assign fall_o = term && clk_q;

  always_comb begin
    cnt_d  = cnt_q;
    clk_d  = clk_q;
    tick_d = 1'b0;
    half_d = load_half ? half_in : half_q;
    if (!run) begin
      cnt_d = '0;
      clk_d = 1'b0;
    end else if (term) begin
      cnt_d  = '0;
      clk_d  = ~clk_q;
      tick_d = ~clk_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
      half_q <= CNT_W'(DEFAULT_HALF);
    end else begin
      cnt_q  <= cnt_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
      half_q <= half_d;
    end
  end

  assign clk_o    = clk_q;
  assign tick_o   = tick_q;
  assign half_cur = half_q;

endmodule

// File: rtl/clk_div_sched.sv
// Glitch-free start/stop/retune sequencer for the programmable clock divider.
// Optional macro CLK_DIV_SCHED_CNT_EN adds the o_EDGE_CNT tick counter output.
module clk_div_sched
  import clk_div_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEF,
  parameter int DEFAULT_HALF = DEFAULT_HALF_DEF
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  input  logic             i_EN,
  input  logic             i_CFG_VALID,
  input  logic [CNT_W-1:0] i_CFG_HALF,
  output logic             o_CFG_READY,
  output logic             o_CLK,
  output logic             o_TICK,
  output logic             o_BUSY,
  output logic [CNT_W-1:0] o_HALF_CUR
`ifdef CLK_DIV_SCHED_CNT_EN
  ,
  output logic [31:0]      o_EDGE_CNT
`endif
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] half_nxt_q, half_nxt_d;
  logic             nxt_vld_q, nxt_vld_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             accept, fall, stop_low, core_run, load_half;
  logic [CNT_W-1:0] cfg_half, half_in;

  assign accept   = i_CFG_VALID && ready_q;
  assign cfg_half = CNT_W'(half_clamp(32'(i_CFG_HALF)));
  // Stopping during a low phase freezes the divider at once so no runt high pulse escapes
  assign stop_low = ((state_q == RUN) || (state_q == PEND)) && !i_EN && !o_CLK;
  assign core_run = (state_q != IDLE) && !stop_low;

  clk_div_core #(.CNT_W(CNT_W), .DEFAULT_HALF(DEFAULT_HALF)) u_core (
    .clk       (i_CLK),
    .rst       (i_RST),
    .run       (core_run),
    .load_half (load_half),
    .half_in   (half_in),
    .clk_o     (o_CLK),
    .tick_o    (o_TICK),
    .fall_o    (fall),
    .half_cur  (o_HALF_CUR)
  );

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q    <= IDLE;
      half_nxt_q <= '0;
      nxt_vld_q  <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      half_nxt_q <= half_nxt_d;
      nxt_vld_q  <= nxt_vld_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = i_EN ? RUN : IDLE;
      RUN: begin
        if (!i_EN)       state_d = (!o_CLK || fall) ? IDLE : STOP;
        else if (accept) state_d = PEND;
        else             state_d = RUN;
      end
      PEND: begin
        if (!i_EN)     state_d = (!o_CLK || fall) ? IDLE : STOP;
        else if (fall) state_d = RUN;
        else           state_d = PEND;
      end
      STOP:    state_d = fall ? IDLE : STOP;
      default: state_d = IDLE;
    endcase
  end

  // A pending half-period is applied only on a 1->0 toggle or on the way into IDLE
  always_comb begin
    load_half  = 1'b0;
    half_in    = half_nxt_q;
    half_nxt_d = half_nxt_q;
    nxt_vld_d  = nxt_vld_q;
    if (accept && ((state_q == IDLE) || (state_d == IDLE))) begin
      load_half = 1'b1;
      half_in   = cfg_half;
    end else if (accept) begin
      half_nxt_d = cfg_half;
      nxt_vld_d  = 1'b1;
    end else if (nxt_vld_q && ((state_d == IDLE) || ((state_q == PEND) && (state_d == RUN)))) begin
      load_half = 1'b1;
      nxt_vld_d = 1'b0;
    end else begin
      load_half = 1'b0;
    end
    ready_d = (state_d == IDLE) || (state_d == RUN);
    busy_d  = (state_d != IDLE);
  end

  assign o_CFG_READY = ready_q;
  assign o_BUSY      = busy_q;

`ifdef CLK_DIV_SCHED_CNT_EN
  logic [31:0] edge_cnt_q, edge_cnt_d;

  always_comb begin
    edge_cnt_d = o_TICK ? (edge_cnt_q + 32'd1) : edge_cnt_q;
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) edge_cnt_q <= 32'd0;
    else       edge_cnt_q <= edge_cnt_d;
  end

  assign o_EDGE_CNT = edge_cnt_q;
`endif

endmodule

// File: tb/tb_clk_div_sched.sv
// Scoreboard bench for clk_div_sched: expected tick cycles are queued as stimulus is
// driven and popped by a monitor; state/handshake outputs are spot-checked per cycle.
module tb_clk_div_sched;

  logic        clk = 1'b0;
  logic        i_RST, i_EN, i_CFG_VALID;
  logic [15:0] i_CFG_HALF;
  logic        o_CFG_READY, o_CLK, o_TICK, o_BUSY;
  logic [15:0] o_HALF_CUR;
`ifdef CLK_DIV_SCHED_CNT_EN
  logic [31:0] o_EDGE_CNT;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int exp_tick_q[$];

  clk_div_sched dut (
    .i_CLK       (clk),
    .i_RST       (i_RST),
    .i_EN        (i_EN),
    .i_CFG_VALID (i_CFG_VALID),
    .i_CFG_HALF  (i_CFG_HALF),
    .o_CFG_READY (o_CFG_READY),
    .o_CLK       (o_CLK),
    .o_TICK      (o_TICK),
    .o_BUSY      (o_BUSY),
    .o_HALF_CUR  (o_HALF_CUR)
`ifdef CLK_DIV_SCHED_CNT_EN
    ,
    .o_EDGE_CNT  (o_EDGE_CNT)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Every o_TICK must match the oldest queued expected cycle
  always @(negedge clk) begin
    int e;
    if (o_TICK === 1'b1) begin
      if (exp_tick_q.size() == 0) begin
        check_eq("tick_unexp", 32'(o_TICK), 32'd0);
      end else begin
        e = exp_tick_q.pop_front();
        check_eq("tick_cyc", 32'(cyc), 32'(e));
      end
    end
  end

  initial begin
    int c0, c1, c2, c3, c4, t;
    i_RST = 1'b1; i_EN = 1'b0; i_CFG_VALID = 1'b0; i_CFG_HALF = 16'd0;
    wait_to(3);
    check_eq("rst_clk",   32'(o_CLK), 32'd0);
    check_eq("rst_tick",  32'(o_TICK), 32'd0);
    check_eq("rst_ready", 32'(o_CFG_READY), 32'd1);
    check_eq("rst_busy",  32'(o_BUSY), 32'd0);
    check_eq("rst_half",  32'(o_HALF_CUR), 32'd10);
`ifdef CLK_DIV_SCHED_CNT_EN
    check_eq("rst_edge",  o_EDGE_CNT, 32'd0);
`endif
    i_RST = 1'b0;

    // Start with default half: rise 10 cycles after RUN entry, period 20
    wait_to(5); c0 = cyc; i_EN = 1'b1;
    for (int k = 0; k < 3; k++) exp_tick_q.push_back(c0 + 11 + 20 * k);
    wait_to(c0 + 1);
    check_eq("run_busy", 32'(o_BUSY), 32'd1);
    check_eq("run_clk0", 32'(o_CLK), 32'd0);
    wait_to(c0 + 10);
    check_eq("run_clk_pre", 32'(o_CLK), 32'd0);
    wait_to(c0 + 21);
    check_eq("run_clk_fall", 32'(o_CLK), 32'd0);

    // Stop at cnt=3 of a high phase: high phase drains, then IDLE
    t = c0 + 51;
    wait_to(t + 3); i_EN = 1'b0;
    wait_to(t + 4);
    check_eq("stop_busy",  32'(o_BUSY), 32'd1);
    check_eq("stop_ready", 32'(o_CFG_READY), 32'd0);
    wait_to(t + 9);
    check_eq("stop_clk_hi", 32'(o_CLK), 32'd1);
    wait_to(t + 10);
    check_eq("stop_clk_lo", 32'(o_CLK), 32'd0);
    check_eq("stop_idle",   32'(o_BUSY), 32'd0);
    check_eq("stop_ready1", 32'(o_CFG_READY), 32'd1);

    // Stop during a low phase: IDLE on the next cycle
    wait_to(t + 12); c1 = cyc; i_EN = 1'b1;
    exp_tick_q.push_back(c1 + 11);
    wait_to(c1 + 23);
    check_eq("lstop_busy0", 32'(o_BUSY), 32'd1);
    check_eq("lstop_clk0",  32'(o_CLK), 32'd0);
    i_EN = 1'b0;
    wait_to(c1 + 24);
    check_eq("lstop_idle", 32'(o_BUSY), 32'd0);
    wait_to(c1 + 40);
    check_eq("lstop_quiet", 32'(o_CLK), 32'd0);

    // Retune to 4 while high: old high phase completes, then 4-cycle phases
    c2 = cyc; i_EN = 1'b1;
    exp_tick_q.push_back(c2 + 11);
    exp_tick_q.push_back(c2 + 31);
    t = c2 + 31;
    wait_to(t + 2);
    check_eq("cfg_ready_pre", 32'(o_CFG_READY), 32'd1);
    check_eq("cfg_clk_hi",    32'(o_CLK), 32'd1);
    i_CFG_VALID = 1'b1; i_CFG_HALF = 16'd4;
    wait_to(t + 3); i_CFG_VALID = 1'b0;
    check_eq("cfg_ready_pend", 32'(o_CFG_READY), 32'd0);
    wait_to(t + 9);
    check_eq("cfg_half_old",  32'(o_HALF_CUR), 32'd10);
    check_eq("cfg_clk_old",   32'(o_CLK), 32'd1);
    check_eq("cfg_ready_hold", 32'(o_CFG_READY), 32'd0);
    wait_to(t + 10);
    check_eq("cfg_half_new", 32'(o_HALF_CUR), 32'd4);
    check_eq("cfg_clk_lo",   32'(o_CLK), 32'd0);
    check_eq("cfg_ready_back", 32'(o_CFG_READY), 32'd1);
    for (int k = 0; k < 3; k++) exp_tick_q.push_back(t + 14 + 8 * k);
    wait_to(t + 31); i_EN = 1'b0;
    wait_to(t + 33);
    check_eq("cfg_stop_hi", 32'(o_CLK), 32'd1);
    check_eq("cfg_stop_busy", 32'(o_BUSY), 32'd1);
    wait_to(t + 34);
    check_eq("cfg_stop_lo", 32'(o_CLK), 32'd0);
    check_eq("cfg_stop_idle", 32'(o_BUSY), 32'd0);

    // Config 0 and enable together in IDLE: half clamps to 1
    wait_to(t + 36); c3 = cyc;
    i_CFG_VALID = 1'b1; i_CFG_HALF = 16'd0; i_EN = 1'b1;
    for (int k = 1; k <= 4; k++) exp_tick_q.push_back(c3 + 2 * k);
    wait_to(c3 + 1); i_CFG_VALID = 1'b0;
    check_eq("div2_half", 32'(o_HALF_CUR), 32'd1);
    check_eq("div2_clk0", 32'(o_CLK), 32'd0);
    wait_to(c3 + 2);
    check_eq("div2_clk1", 32'(o_CLK), 32'd1);
    wait_to(c3 + 3);
    check_eq("div2_clk2", 32'(o_CLK), 32'd0);

    // Reset in the middle of PEND with half_nxt=6 pending
    wait_to(c3 + 8);
    check_eq("pend_ready_pre", 32'(o_CFG_READY), 32'd1);
    i_CFG_VALID = 1'b1; i_CFG_HALF = 16'd6;
    wait_to(c3 + 9); i_CFG_VALID = 1'b0;
    check_eq("pend_ready", 32'(o_CFG_READY), 32'd0);
    check_eq("pend_busy",  32'(o_BUSY), 32'd1);
    i_RST = 1'b1; i_EN = 1'b0;
    wait_to(c3 + 10);
    check_eq("mrst_clk",   32'(o_CLK), 32'd0);
    check_eq("mrst_tick",  32'(o_TICK), 32'd0);
    check_eq("mrst_ready", 32'(o_CFG_READY), 32'd1);
    check_eq("mrst_busy",  32'(o_BUSY), 32'd0);
    check_eq("mrst_half",  32'(o_HALF_CUR), 32'd10);
    i_RST = 1'b0;

    // Five periods at half 10 (6 must never appear), then stop and hold
    wait_to(c3 + 12); c4 = cyc; i_EN = 1'b1;
    for (int k = 0; k < 5; k++) exp_tick_q.push_back(c4 + 11 + 20 * k);
    wait_to(c4 + 93); i_EN = 1'b0;
    check_eq("five_half", 32'(o_HALF_CUR), 32'd10);
    wait_to(c4 + 100);
    check_eq("five_clk_hi", 32'(o_CLK), 32'd1);
    wait_to(c4 + 101);
    check_eq("five_idle", 32'(o_BUSY), 32'd0);
    check_eq("five_half_end", 32'(o_HALF_CUR), 32'd10);
`ifdef CLK_DIV_SCHED_CNT_EN
    wait_to(c4 + 110);
    check_eq("edge_cnt", o_EDGE_CNT, 32'd5);
`endif
    wait_to(c4 + 130);
    check_eq("idle_clk", 32'(o_CLK), 32'd0);
`ifdef CLK_DIV_SCHED_CNT_EN
    check_eq("edge_hold", o_EDGE_CNT, 32'd5);
`endif
    check_eq("tick_missing", 32'(exp_tick_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
